// File: rtl/nibble_serial_adder_ctrl.sv
// Sequencer for an external 4-bit adder: takes a wide operand pair, feeds it nibble by nibble
// (LSB first) with carry chaining, and returns sum, carry-out and signed overflow.
module nibble_serial_adder_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic [3:0]             add_x,
    output logic [3:0]             add_y,
    output logic                   add_cin,
    input  logic [3:0]             add_s,
    input  logic                   add_cout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   overflow
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state;
    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;
    logic [W-1:0]    sum_sh;
    logic [W-1:0]    sum_next;
    logic            carry;
    logic [CW-1:0]   cnt;
    logic            a_msb;
    logic            b_msb;

    // New sum nibble enters at the top so the LSB nibble ends up at bit 0 after NIBBLES shifts.
    assign sum_next = (sum_sh >> 4) | (W'(add_s) << (W - 4));

    assign add_x   = (state == StRun) ? a_sh[3:0] : 4'h0;
    assign add_y   = (state == StRun) ? b_sh[3:0] : 4'h0;
    assign add_cin = (state == StRun) ? carry : 1'b0;
    assign sum     = sum_sh;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StIdle;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        carry    <= cin;
                        a_msb    <= a[W-1];
                        b_msb    <= b[W-1];
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= StRun;
                    end
                end
                StRun: begin
                    sum_sh <= sum_next;
                    a_sh   <= a_sh >> 4;
                    b_sh   <= b_sh >> 4;
                    carry  <= add_cout;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LastCnt) begin
                        cout      <= add_cout;
                        overflow  <= (a_msb == b_msb) && (add_s[3] != a_msb);
                        out_valid <= 1'b1;
                        state     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl: NIBBLES=4 and NIBBLES=1 instances, each driving a
// behavioural 4-bit adder, checked against a plain-arithmetic reference.
module tb_nibble_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          errors = 0;
    int          checks = 0;

    // NIBBLES=4 instance
    logic        in_valid = 1'b0, in_ready, cin = 1'b0, add_cin, add_cout;
    logic [15:0] a = '0, b = '0, sum;
    logic [3:0]  add_x, add_y, add_s;
    logic        out_valid, out_ready = 1'b0, cout, overflow;

    // NIBBLES=1 instance
    logic        in_valid1 = 1'b0, in_ready1, cin1 = 1'b0, add_cin1, add_cout1;
    logic [3:0]  a1 = '0, b1 = '0, sum1;
    logic [3:0]  add_x1, add_y1, add_s1;
    logic        out_valid1, out_ready1 = 1'b0, cout1, overflow1;

    logic [15:0] hold_a, hold_b;
    logic        hold_c;
    int          last_wait;

    always #5 clk = ~clk;

    assign {add_cout, add_s}   = {1'b0, add_x} + {1'b0, add_y} + {4'b0, add_cin};
    assign {add_cout1, add_s1} = {1'b0, add_x1} + {1'b0, add_y1} + {4'b0, add_cin1};

    nibble_serial_adder_ctrl #(.NIBBLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .add_x(add_x), .add_y(add_y), .add_cin(add_cin), .add_s(add_s),
        .add_cout(add_cout), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .overflow(overflow)
    );

    nibble_serial_adder_ctrl #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
        .cin(cin1), .add_x(add_x1), .add_y(add_y1), .add_cin(add_cin1), .add_s(add_s1),
        .add_cout(add_cout1), .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1),
        .cout(cout1), .overflow(overflow1)
    );

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, sum, cout, overflow, add_x, add_y, add_cin} !== 30'd0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b vld=%b sum=%h c=%b o=%b x=%h y=%h ci=%b exp all 0",
                     in_ready, out_valid, sum, cout, overflow, add_x, add_y, add_cin);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_reset got rdy=%b vld=%b rdy1=%b exp 1 0 1",
                     in_ready, out_valid, in_ready1);
        end
    endtask

    // One full operation on the NIBBLES=4 instance; hold>0 keeps out_ready low that many cycles
    // while new operands sit on the input with in_valid high.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv, input logic tc,
                          input int hold);
        logic [16:0] full;
        logic [15:0] es;
        logic        ec, eo, c;
        logic [4:0]  t5;
        int          n;
        full = {1'b0, ta} + {1'b0, tbv} + 17'(tc);
        es   = full[15:0];
        ec   = full[16];
        eo   = (ta[15] == tbv[15]) && (es[15] != ta[15]);
        @(negedge clk);
        in_valid = 1'b1; a = ta; b = tbv; cin = tc; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        last_wait = n;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout got in_ready=%b exp 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        c = tc;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({add_x, add_y, add_cin, out_valid, in_ready} !== {ta[4*i+:4], tbv[4*i+:4], c, 2'b00})
            begin
                errors++;
                $display("FAIL run_nibble%0d got x=%h y=%h ci=%b vld=%b rdy=%b exp x=%h y=%h ci=%b 0 0",
                         i, add_x, add_y, add_cin, out_valid, in_ready, ta[4*i+:4], tbv[4*i+:4], c);
            end
            t5 = {1'b0, ta[4*i+:4]} + {1'b0, tbv[4*i+:4]} + {4'b0, c};
            c  = t5[4];
            @(posedge clk);
            #1;
        end
        checks++;
        if ({out_valid, in_ready, sum, cout, overflow, add_x} !== {2'b10, es, ec, eo, 4'h0}) begin
            errors++;
            $display("FAIL result a=%h b=%h ci=%b got vld=%b rdy=%b sum=%h c=%b o=%b x=%h exp 1 0 %h %b %b 0",
                     ta, tbv, tc, out_valid, in_ready, sum, cout, overflow, add_x, es, ec, eo);
        end
        hold_a = 16'($urandom); hold_b = 16'($urandom); hold_c = 1'($urandom);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; a = hold_a; b = hold_b; cin = hold_c;
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, in_ready, sum, cout, overflow} !== {2'b10, es, ec, eo}) begin
                errors++;
                $display("FAIL backpressure_hold%0d got vld=%b rdy=%b sum=%h c=%b o=%b exp 1 0 %h %b %b",
                         i, out_valid, in_ready, sum, cout, overflow, es, ec, eo);
            end
        end
        if (hold == 0) in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL handshake_release got vld=%b rdy=%b exp 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_directed;
        run_op(16'h1234, 16'h4321, 1'b1, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 0);
        run_op(16'h8000, 16'h8000, 1'b0, 0);
    endtask

    task automatic test_backpressure;
        run_op(16'h2468, 16'h1357, 1'b0, 5);
        // The held operands must be taken on the very next edge.
        run_op(hold_a, hold_b, hold_c, 0);
        checks++;
        if (last_wait != 0) begin
            errors++;
            $display("FAIL accept_after_release got wait=%0d exp 0", last_wait);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 12; i++)
            run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        run_op(16'($urandom), 16'($urandom), 1'($urandom), 0);
    endtask

    task automatic test_reset_mid_run;
        int n;
        bit seen;
        @(negedge clk);
        a = 16'hABCD; b = 16'h1111; cin = 1'b1; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, sum, cout, overflow, add_x, add_y, add_cin} !== 30'd0) begin
            errors++;
            $display("FAIL mid_run_reset got rdy=%b vld=%b sum=%h c=%b o=%b x=%h y=%h ci=%b exp all 0",
                     in_ready, out_valid, sum, cout, overflow, add_x, add_y, add_cin);
        end
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL aborted_op_signalled got out_valid pulse=1 exp 0");
        end
        run_op(16'h0F0F, 16'h0101, 1'b0, 0);
    endtask

    task automatic test_back_to_back;
        logic [16:0] q[$];
        logic [16:0] exp_v;
        int          acc[$];
        bit          took;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            took = 1'b0;
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_spurious got out_valid=1 exp no pending op");
                end else begin
                    exp_v = q.pop_front();
                    if ({cout, sum} !== exp_v) begin
                        errors++;
                        $display("FAIL b2b_result got %h exp %h", {cout, sum}, exp_v);
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back({1'b0, a} + {1'b0, b} + 17'(cin));
                acc.push_back(cyc);
                took = 1'b1;
            end
            @(posedge clk);
            #1;
            if (took) begin
                a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            end
        end
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (acc.size() < 8) begin
            errors++;
            $display("FAIL b2b_accept_count got %0d exp >=8", acc.size());
        end
        for (int i = 1; i < acc.size(); i++) begin
            checks++;
            if (acc[i] - acc[i-1] != 6) begin
                errors++;
                $display("FAIL b2b_spacing%0d got %0d exp 6", i, acc[i] - acc[i-1]);
            end
        end
    endtask

    task automatic test_nibbles1;
        logic [5:0] q[$];
        logic [5:0] exp_v;
        logic [4:0] f;
        int         acc[$];
        bit         took;
        a1 = 4'hF; b1 = 4'h1; cin1 = 1'b0;
        in_valid1 = 1'b1; out_ready1 = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            took = 1'b0;
            if (out_valid1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL n1_spurious got out_valid=1 exp no pending op");
                end else begin
                    exp_v = q.pop_front();
                    if ({overflow1, cout1, sum1} !== exp_v) begin
                        errors++;
                        $display("FAIL n1_result got o/c/sum=%b exp %b",
                                 {overflow1, cout1, sum1}, exp_v);
                    end
                end
            end
            if (in_valid1 && in_ready1) begin
                f = {1'b0, a1} + {1'b0, b1} + {4'b0, cin1};
                q.push_back({(a1[3] == b1[3]) && (f[3] != a1[3]), f});
                acc.push_back(cyc);
                took = 1'b1;
            end
            @(posedge clk);
            #1;
            if (took) begin
                a1 = 4'($urandom); b1 = 4'($urandom); cin1 = 1'($urandom);
            end
        end
        in_valid1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        out_ready1 = 1'b0;
        checks++;
        if (acc.size() < 8) begin
            errors++;
            $display("FAIL n1_accept_count got %0d exp >=8", acc.size());
        end
        for (int i = 1; i < acc.size(); i++) begin
            checks++;
            if (acc[i] - acc[i-1] != 3) begin
                errors++;
                $display("FAIL n1_spacing%0d got %0d exp 3", i, acc[i] - acc[i-1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid_run();
        test_back_to_back();
        test_nibbles1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
